// File: rtl/addecrc_pad.sv
// addecrc_pad: TX-path zero padder and reflected CRC appender.
// Forwards DW-bit beats with one beat of latency. It can zero-pad a short
// frame up to MIN_BEATS, and it can then append the CRC least-significant beat first.
module addecrc_pad #(
  parameter int unsigned     DW        = 8,
  parameter int unsigned     CRCW      = 32,
  parameter logic [CRCW-1:0] TAPS      = 32'hedb88320,
  parameter logic [CRCW-1:0] INIT      = 32'hffffffff,
  parameter logic [CRCW-1:0] FINAL_XOR = 32'hffffffff,
  parameter int unsigned     MIN_BEATS = 60
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_en,
  input  logic          i_pad_en,
  input  logic          i_v,
  input  logic [DW-1:0] i_d,
  output logic          o_v,
  output logic [DW-1:0] o_d,
  output logic          o_busy,
  output logic          o_err
);

  localparam int unsigned NB   = CRCW / DW;
  localparam int unsigned BCW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned CNTW = (MIN_BEATS > 0) ? $clog2(MIN_BEATS + 1) : 1;

  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(MIN_BEATS);
  localparam logic [BCW-1:0]  BEAT_LAST = BCW'(NB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_CRC  = 2'd3;

  // With a single-beat CRC there is nothing left to send after beat 0.
  localparam logic [1:0] S_AFTER_BEAT0 = (NB > 1) ? S_CRC : S_IDLE;

  logic [1:0]      state, state_n;
  logic [CRCW-1:0] crc, crc_n;
  logic [CNTW-1:0] cnt, cnt_n;
  logic [BCW-1:0]  bcnt, bcnt_n;
  logic            r_en, r_en_n;
  logic            r_pad, r_pad_n;
  logic            v_n;
  logic [DW-1:0]   d_n;
  logic            err_n;

  logic [CNTW-1:0] cnt_inc;
  logic            below_min;
  logic [DW-1:0]   crc_beat;
  logic [CRCW-1:0] crc_shift;

  // Reflected LFSR advanced over one beat, bit 0 of the beat first.
  function automatic logic [CRCW-1:0] crc_step(input logic [CRCW-1:0] c,
                                               input logic [DW-1:0]   d);
    logic [CRCW-1:0] r;
    logic            fb;
    r = c;
    for (int k = 0; k < int'(DW); k++) begin
      fb = r[0] ^ d[k];
      r  = (r >> 1) ^ (fb ? TAPS : '0);
    end
    return r;
  endfunction

  assign o_busy    = (state == S_PAD) || (state == S_CRC);
  assign below_min = (cnt < CNT_MAX);
  assign cnt_inc   = below_min ? (cnt + CNTW'(1)) : cnt;
  assign crc_beat  = crc[DW-1:0] ^ FINAL_XOR[DW-1:0];
  assign crc_shift = crc >> DW;

  // Next-state and next-output decode for every register.
  always_comb begin
    state_n = state;
    crc_n   = crc;
    cnt_n   = cnt;
    bcnt_n  = bcnt;
    r_en_n  = r_en;
    r_pad_n = r_pad;
    v_n     = 1'b0;
    d_n     = '0;
    err_n   = i_v && o_busy;

    case (state)
      S_IDLE: begin
        if (i_v) begin
          v_n     = 1'b1;
          d_n     = i_d;
          crc_n   = crc_step(INIT, i_d);
          cnt_n   = CNTW'(1);
          r_en_n  = i_en;
          r_pad_n = i_pad_en;
          state_n = S_DATA;
        end else begin
          crc_n = INIT;
        end
      end

      S_DATA: begin
        if (i_v) begin
          v_n   = 1'b1;
          d_n   = i_d;
          crc_n = crc_step(crc, i_d);
          cnt_n = cnt_inc;
        end else if (r_pad && below_min) begin
          v_n     = 1'b1;
          crc_n   = crc_step(crc, '0);
          cnt_n   = cnt_inc;
          state_n = S_PAD;
        end else if (r_en) begin
          v_n     = 1'b1;
          d_n     = crc_beat;
          crc_n   = crc_shift;
          bcnt_n  = BCW'(1);
          state_n = S_AFTER_BEAT0;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_PAD: begin
        if (below_min) begin
          v_n   = 1'b1;
          crc_n = crc_step(crc, '0);
          cnt_n = cnt_inc;
        end else if (r_en) begin
          v_n     = 1'b1;
          d_n     = crc_beat;
          crc_n   = crc_shift;
          bcnt_n  = BCW'(1);
          state_n = S_AFTER_BEAT0;
        end else begin
          state_n = S_IDLE;
        end
      end

      S_CRC: begin
        v_n    = 1'b1;
        d_n    = crc_beat;
        crc_n  = crc_shift;
        bcnt_n = bcnt + BCW'(1);
        if (bcnt == BEAT_LAST) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        crc_n   = INIT;
      end
    endcase
  end

  // State and output registers; everything holds while i_ce is low.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      crc   <= INIT;
      cnt   <= '0;
      bcnt  <= '0;
      r_en  <= 1'b0;
      r_pad <= 1'b0;
      o_v   <= 1'b0;
      o_d   <= '0;
      o_err <= 1'b0;
    end else if (i_ce) begin
      state <= state_n;
      crc   <= crc_n;
      cnt   <= cnt_n;
      bcnt  <= bcnt_n;
      r_en  <= r_en_n;
      r_pad <= r_pad_n;
      o_v   <= v_n;
      o_d   <= d_n;
      o_err <= err_n;
    end
  end

endmodule

// File: tb/tb_addecrc_pad.sv
// tb_addecrc_pad: directed and randomized checks of addecrc_pad for byte and nibble beats.
module tb_addecrc_pad;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;

  logic       v8 = 1'b0, en8 = 1'b0, pad8 = 1'b0;
  logic [7:0] d8 = '0;
  logic       ov8, busy8, err8;
  logic [7:0] od8;

  logic       v4 = 1'b0, en4 = 1'b0, pad4 = 1'b0;
  logic [3:0] d4 = '0;
  logic       ov4, busy4, err4;
  logic [3:0] od4;

  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  bit         seen_v, ended, busy_seen, injected;
  logic       cur_busy, cur_err;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] expq[$];
  logic [31:0] known;

  always #5 clk = ~clk;

  addecrc_pad #(.DW(8), .MIN_BEATS(60)) dut8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_en(en8), .i_pad_en(pad8),
    .i_v(v8), .i_d(d8), .o_v(ov8), .o_d(od8), .o_busy(busy8), .o_err(err8)
  );

  addecrc_pad #(.DW(4), .MIN_BEATS(120)) dut4 (
    .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_en(en4), .i_pad_en(pad4),
    .i_v(v4), .i_d(d4), .o_v(ov4), .o_d(od4), .o_busy(busy4), .o_err(err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 over the beat list, nb bits per beat, bit 0 first.
  function automatic logic [31:0] model_crc(input logic [7:0] q[$], input int nb);
    logic [31:0] c;
    c = 32'hffffffff;
    foreach (q[i]) begin
      for (int k = 0; k < nb; k++) begin
        if (c[0] ^ q[i][k]) c = (c >> 1) ^ 32'hedb88320;
        else                c = c >> 1;
      end
    end
    return c ^ 32'hffffffff;
  endfunction

  // Expected output: data, zero pad up to the minimum, then the CRC LSB beat first.
  task automatic build_exp(input logic en, input logic pad);
    int nb, minb;
    logic [31:0] c;
    nb   = (sel == 0) ? 8 : 4;
    minb = (sel == 0) ? 60 : 120;
    expq = txq;
    if (pad) while (expq.size() < minb) expq.push_back(8'h00);
    if (en) begin
      c = model_crc(expq, nb);
      for (int j = 0; j < 32 / nb; j++)
        expq.push_back(8'((c >> (j * nb)) & ((32'd1 << nb) - 1)));
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (sel == 0) begin v8 = v; d8 = d; end
    else begin v4 = v; d4 = d[3:0]; end
  endtask

  task automatic mode(input logic en, input logic pad);
    if (sel == 0) begin en8 = en; pad8 = pad; end
    else begin en4 = en; pad4 = pad; end
  endtask

  // One clock; captures the selected DUT's outputs only on enabled cycles.
  task automatic tick(input logic ce_val);
    logic       cv;
    logic [7:0] cd;
    ce = ce_val;
    @(posedge clk);
    #1;
    if (ce_val) begin
      cv       = (sel == 0) ? ov8 : ov4;
      cd       = (sel == 0) ? od8 : {4'h0, od4};
      cur_busy = (sel == 0) ? busy8 : busy4;
      cur_err  = (sel == 0) ? err8 : err4;
      if (cv) begin
        rxq.push_back(cd);
        seen_v = 1'b1;
      end else if (seen_v) begin
        ended = 1'b1;
      end
      if (cur_busy) busy_seen = 1'b1;
    end
  endtask

  task automatic send_frame(input logic en, input logic pad, input bit toggle, input bit inject);
    rxq.delete();
    seen_v = 0; ended = 0; busy_seen = 0; injected = 0;
    mode(en, pad);
    foreach (txq[i]) begin
      drive(1'b1, txq[i]);
      if (toggle) tick(1'b0);
      tick(1'b1);
      mode(1'($urandom), 1'($urandom));
    end
    drive(1'b0, 8'h00);
    for (int n = 0; n < 600 && !ended; n++) begin
      if (inject && !injected && cur_busy) begin
        drive(1'b1, 8'($urandom));
        tick(1'b1);
        chk("err pulse", 32'(cur_err), 32'd1);
        drive(1'b0, 8'h00);
        tick(1'b1);
        chk("err clear", 32'(cur_err), 32'd0);
        injected = 1;
      end else begin
        if (toggle) tick(1'b0);
        tick(1'b1);
      end
    end
    chk("frame end", 32'(ended), 32'd1);
    if (inject) chk("inject done", 32'(injected), 32'd1);
  endtask

  task automatic cmp_frame(input string tag);
    chk({tag, " len"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < rxq.size() && i < expq.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(rxq[i]), 32'(expq[i]));
  endtask

  task automatic load_123456789_bytes();
    txq.delete();
    for (int b = 8'h31; b <= 8'h39; b++) txq.push_back(8'(b));
  endtask

  task automatic exp_known_bytes();
    expq = txq;
    for (int j = 0; j < 4; j++) expq.push_back(known[j*8 +: 8]);
  endtask

  initial begin
    int len;
    logic en, pad;
    known = 32'hcbf43926;

    // Reset state, during and just after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst ov8", 32'(ov8), 0);
    chk("rst od8", 32'(od8), 0);
    chk("rst err8", 32'(err8), 0);
    chk("rst busy8", 32'(busy8), 0);
    chk("rst ov4", 32'(ov4), 0);
    chk("rst busy4", 32'(busy4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    chk("idle od8", 32'(od8), 0);
    chk("idle ov4", 32'(ov4), 0);

    // Byte frame "123456789" with CRC.
    sel = 0;
    load_123456789_bytes();
    send_frame(1'b1, 1'b0, 0, 0);
    exp_known_bytes();
    cmp_frame("t1 bytes");

    // Nibble frame, low nibble first.
    sel = 1;
    txq.delete();
    for (int b = 8'h31; b <= 8'h39; b++) begin
      txq.push_back(8'(b & 8'h0f));
      txq.push_back(8'(b >> 4));
    end
    send_frame(1'b1, 1'b0, 0, 0);
    expq = txq;
    for (int j = 0; j < 8; j++) expq.push_back(8'(known[j*4 +: 4]));
    cmp_frame("t2 nibbles");

    // Single byte padded to 60, then CRC.
    sel = 0;
    txq.delete();
    txq.push_back(8'haa);
    send_frame(1'b1, 1'b1, 0, 0);
    build_exp(1'b1, 1'b1);
    chk("t3 total", 32'(rxq.size()), 32'd64);
    cmp_frame("t3 pad");

    // Plain pass-through, no CRC, never busy.
    txq.delete();
    txq.push_back(8'h01); txq.push_back(8'h02); txq.push_back(8'h03);
    send_frame(1'b0, 1'b0, 0, 0);
    expq = txq;
    cmp_frame("t4 plain");
    chk("t4 busy", 32'(busy_seen), 32'd0);

    // Clock enable toggling gives the same beats.
    load_123456789_bytes();
    send_frame(1'b1, 1'b0, 1, 0);
    exp_known_bytes();
    cmp_frame("t5 ce");

    // Valid during CRC: error pulse, CRC untouched.
    send_frame(1'b1, 1'b0, 0, 1);
    cmp_frame("t5 inject");

    // Reset while CRC beat 2 is on the output.
    rxq.delete();
    seen_v = 0; ended = 0;
    mode(1'b1, 1'b0);
    foreach (txq[i]) begin
      drive(1'b1, txq[i]);
      tick(1'b1);
    end
    drive(1'b0, 8'h00);
    for (int n = 0; n < 20 && rxq.size() < 12; n++) tick(1'b1);
    chk("t6 reached beat2", 32'(rxq.size()), 32'd12);
    chk("t6 beat2", 32'(rxq[rxq.size()-1]), 32'hf4);
    rst_n = 1'b0;
    #2;
    chk("t6 async ov", 32'(ov8), 0);
    chk("t6 async busy", 32'(busy8), 0);
    tick(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1);
    send_frame(1'b1, 1'b0, 0, 0);
    exp_known_bytes();
    cmp_frame("t6 after rst");

    // Randomized byte frames against the reference model.
    sel = 0;
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(1, 70);
      en  = 1'($urandom);
      pad = 1'($urandom);
      txq.delete();
      for (int i = 0; i < len; i++) txq.push_back(8'($urandom));
      send_frame(en, pad, 0, 0);
      build_exp(en, pad);
      cmp_frame($sformatf("rnd8 #%0d", r));
    end

    // Randomized nibble frames against the reference model.
    sel = 1;
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 130);
      en  = 1'($urandom);
      pad = 1'($urandom);
      txq.delete();
      for (int i = 0; i < len; i++) txq.push_back(8'($urandom_range(0, 15)));
      send_frame(en, pad, 0, 0);
      build_exp(en, pad);
      cmp_frame($sformatf("rnd4 #%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addecrc_pad.md
Name: addecrc_pad

Overview:
- Parametrised successor to the Ethernet TX CRC appender.
- Sits between the TX framer and the RMII/RGMII nibble/byte serializer.
- Accepts a frame as a stream of DW-bit beats and forwards it with one beat of latency.
- Optionally zero-pads the frame to a minimum length, then optionally appends a CRCW-bit reflected CRC, least-significant beat first.

Parameters:
- DW, 8: beat width in bits; 8 (byte) or 4 (nibble). CRCW % DW == 0.
- CRCW, 32: CRC width in bits.
- TAPS, 32'hedb88320: reflected polynomial, CRCW bits.
- INIT, 32'hffffffff: CRC preset at frame start.
- FINAL_XOR, 32'hffffffff: XOR applied to CRC beats as they are emitted.
- MIN_BEATS, 60: minimum payload beats before the CRC when padding is enabled. Use 120 for DW=4.

Ports:
- i_clk, in, 1: clock.
- i_reset_n, in, 1: asynchronous active-low reset.
- i_ce, in, 1: clock enable; all state holds when low.
- i_en, in, 1: append CRC. Sampled on the first beat of a frame.
- i_pad_en, in, 1: pad to MIN_BEATS. Sampled on the first beat of a frame.
- i_v, in, 1: input beat valid. Contiguous within a frame.
- i_d, in, DW: input beat.
- o_v, out, 1: output beat valid.
- o_d, out, DW: output beat.
- o_busy, out, 1: high while in PAD or CRC; upstream must hold i_v low.
- o_err, out, 1: one-ce-cycle pulse when i_v is seen while o_busy.

Behaviour:
- Reset (async, i_reset_n low): state=IDLE, o_v=0, o_d=0, o_err=0, crc=INIT, cnt=0, r_en=0, r_pad=0. Released synchronously.
- All updates below occur only on cycles with i_ce=1. With i_ce=0, every register holds, including o_err.
- CRC step per beat, for k=0..DW-1 in order:
  - fb = crc[0] ^ d[k]
  - crc = (crc>>1) ^ (fb ? TAPS : 0)
- cnt saturates at MIN_BEATS and counts every beat output as payload, data or pad.
- States:
  - IDLE, i_v=1: o_v<=1, o_d<=i_d, crc<=step(INIT,i_d), cnt<=1, r_en<=i_en, r_pad<=i_pad_en; go to DATA.
  - IDLE, i_v=0: o_v<=0, o_d<=0, crc<=INIT.
  - DATA, i_v=1: o_v<=1, o_d<=i_d, crc<=step(crc,i_d), cnt++.
  - DATA, i_v=0:
    - if r_pad and cnt<MIN_BEATS: emit a 0 beat, step crc with 0, cnt++, go to PAD;
    - else if r_en: emit the first CRC beat, go to CRC;
    - else: o_v<=0, go to IDLE.
  - PAD: emit 0 beats, stepping crc, until cnt reaches MIN_BEATS. On the ce cycle after the last pad beat: first CRC beat if r_en, else o_v<=0 and go to IDLE.
  - CRC: beat j (0..CRCW/DW-1) drives o_d = (crc ^ FINAL_XOR)[DW-1:0], then crc<=crc>>DW. This uses a beat counter of width clog2(CRCW/DW). The transition after beat CRCW/DW-1 is IDLE.
- Latency: input beat n appears on o_d one ce-cycle later. Padding/CRC beats follow the last data beat with no gap.
- Back-to-back frames: i_v in IDLE on the cycle after the last CRC beat starts a new frame; o_v stays high. Inserting the IPG is upstream's job.
- o_busy is decoded from registered state (PAD or CRC). i_v while o_busy: beat dropped, CRC unaffected, o_err<=1 for that ce cycle; otherwise o_err<=0.
- Padding disabled or frame already ≥MIN_BEATS: no pad beats.
- i_en/i_pad_en changes mid-frame have no effect.
- Async reset mid-frame: o_v drops immediately. The next frame is computed from INIT.

Test Plan:
- DW=8, i_en=1, i_pad_en=0, i_d=31..39 ("123456789") -> o_d 31..39, then 26,39,F4,CB (CRC CBF43926); o_v low on the next cycle.
- DW=4, same string low nibble first (1,3,2,3,...,9,3) -> data nibbles echoed, then 6,2,9,3,4,F,B,C.
- DW=8, i_pad_en=1, i_en=1, one beat 0xAA -> AA, 59 beats of 00, 4 CRC beats matching a software model of AA+59×00; total o_v high = 64 cycles.
- i_en=0, i_pad_en=0, beats 01,02,03 -> 01,02,03 then o_v=0; no CRC beats; o_busy never high.
- i_ce toggling 1/0 with the test-1 frame -> identical o_d sequence, sampled on ce cycles only; i_v during CRC -> o_err=1 for one ce cycle and CRC bytes unchanged.
- Assert i_reset_n low during CRC beat 2 -> o_v=0 asynchronously; the following "123456789" frame yields 26,39,F4,CB.
